// File: rtl/arbitro_logica_if.sv
// -----------------------------------------------------------------------------
// arbitro_logica_if
// Bundle of the requester-side and logic-unit-side signals of arbitro_logica.
//
// Signals (direction seen from the arbiter, i.e. the slave modport):
//   req          in   4        request level, one bit per requester
//   op_bus       in   8        opcodes, requester i on [2i+1:2i]
//   a_bus        in   4*WIDTH  operand A, requester i on slice i
//   b_bus        in   4*WIDTH  operand B, requester i on slice i
//   alu_res      in   WIDTH    combinational result of the logic unit
//   gnt          out  4        one-hot grant
//   dec_enable   out  1        decoder enable
//   dec_selector out  2        decoder selector (latched opcode)
//   alu_a        out  WIDTH    latched operand A
//   alu_b        out  WIDTH    latched operand B
//   resp_valid   out  1        one-cycle result pulse
//   resp_id      out  2        requester index of the result
//   resp_data    out  WIDTH    captured result
//
// The master modport is the environment: the requesters plus the logic unit.
// -----------------------------------------------------------------------------
interface arbitro_logica_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req;
  logic [7:0]         op_bus;
  logic [4*WIDTH-1:0] a_bus;
  logic [4*WIDTH-1:0] b_bus;
  logic [WIDTH-1:0]   alu_res;
  logic [3:0]         gnt;
  logic               dec_enable;
  logic [1:0]         dec_selector;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic               resp_valid;
  logic [1:0]         resp_id;
  logic [WIDTH-1:0]   resp_data;

  modport master (
    output req, op_bus, a_bus, b_bus, alu_res,
    input  gnt, dec_enable, dec_selector, alu_a, alu_b,
           resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req, op_bus, a_bus, b_bus, alu_res,
    output gnt, dec_enable, dec_selector, alu_a, alu_b,
           resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/arbitro_logica.sv
// -----------------------------------------------------------------------------
// arbitro_logica
// Round-robin scheduler sharing one AND/OR/NAND/XOR logic unit among four
// requesters. A winner's opcode and operands are latched at grant, the decoder
// is enabled for EXEC_CYCLES cycles, the unit's result is captured on the last
// execute edge and returned with the winner's index as a one-cycle pulse.
//
// Parameters:
//   WIDTH        operand/result width (must match the interface WIDTH)
//   EXEC_CYCLES  cycles dec_enable stays high per operation, legal 1..15
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    arbitro_logica_if.slave (requests, operands, logic unit, response)
// -----------------------------------------------------------------------------
module arbitro_logica #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  arbitro_logica_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_win;
  logic [3:0]       r_cnt;
  logic [3:0]       r_gnt;
  logic             r_en;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_rv;
  logic [1:0]       r_rid;
  logic [WIDTH-1:0] r_rdata;

  logic [1:0]       w_win;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  // First set request bit at or above ptr, wrapping 3 -> 0. Scanning from the
  // farthest offset down lets the nearest hit overwrite the others.
  function automatic logic [1:0] f_pick(input logic [3:0] req,
                                        input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] res;
    res = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) res = idx;
    end
    return res;
  endfunction

  assign w_win = f_pick(bus.req, r_ptr);
  assign w_op  = bus.op_bus[2*int'(w_win) +: 2];
  assign w_a   = bus.a_bus[WIDTH*int'(w_win) +: WIDTH];
  assign w_b   = bus.b_bus[WIDTH*int'(w_win) +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_win   <= 2'd0;
      r_cnt   <= 4'd0;
      r_gnt   <= 4'd0;
      r_en    <= 1'b0;
      r_sel   <= 2'b00;
      r_a     <= '0;
      r_b     <= '0;
      r_rv    <= 1'b0;
      r_rid   <= 2'd0;
      r_rdata <= '0;
    end else begin
      r_rv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_win   <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_sel   <= w_op;
            r_a     <= w_a;
            r_b     <= w_b;
            r_en    <= 1'b1;
            r_cnt   <= CNT_LOAD;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // alu_res is only trusted on the final execute edge.
          if (r_cnt == 4'd0) begin
            r_rdata <= bus.alu_res;
            r_rid   <= r_win;
            r_en    <= 1'b0;
            r_sel   <= 2'b00;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_rv    <= 1'b1;
          r_ptr   <= r_win + 2'd1;
          r_gnt   <= 4'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.dec_enable   = r_en;
  assign bus.dec_selector = r_sel;
  assign bus.alu_a        = r_a;
  assign bus.alu_b        = r_b;
  assign bus.resp_valid   = r_rv;
  assign bus.resp_id      = r_rid;
  assign bus.resp_data    = r_rdata;

endmodule

// File: tb/tb_arbitro_logica.sv
module tb_arbitro_logica;

  logic clk = 1'b0;
  logic rst_n1 = 1'b0;
  logic rst_n3 = 1'b0;
  always #5 clk = ~clk;

  arbitro_logica_if #(.WIDTH(8)) if1();
  arbitro_logica_if #(.WIDTH(8)) if3();

  arbitro_logica #(.WIDTH(8), .EXEC_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .bus   (if1)
  );

  arbitro_logica #(.WIDTH(8), .EXEC_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n3),
    .bus   (if3)
  );

  // Reference logic unit: 00 AND, 01 OR, 10 NAND, 11 XOR.
  function automatic logic [7:0] lu(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a & b);
      default: return a ^ b;
    endcase
  endfunction

  assign if1.alu_res = lu(if1.dec_selector, if1.alu_a, if1.alu_b);
  assign if3.alu_res = lu(if3.dec_selector, if3.alu_a, if3.alu_b);

  // Observation mux: cur selects which instance the tasks look at.
  bit cur = 1'b0;
  wire [3:0] m_gnt   = cur ? if3.gnt          : if1.gnt;
  wire       m_en    = cur ? if3.dec_enable   : if1.dec_enable;
  wire [1:0] m_sel   = cur ? if3.dec_selector : if1.dec_selector;
  wire [7:0] m_a     = cur ? if3.alu_a        : if1.alu_a;
  wire [7:0] m_b     = cur ? if3.alu_b        : if1.alu_b;
  wire       m_rv    = cur ? if3.resp_valid   : if1.resp_valid;
  wire [1:0] m_rid   = cur ? if3.resp_id      : if1.resp_id;
  wire [7:0] m_rdata = cur ? if3.resp_data    : if1.resp_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_slice(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (cur) begin
      if3.op_bus[2*id +: 2] = op; if3.a_bus[8*id +: 8] = a; if3.b_bus[8*id +: 8] = b;
    end else begin
      if1.op_bus[2*id +: 2] = op; if1.a_bus[8*id +: 8] = a; if1.b_bus[8*id +: 8] = b;
    end
  endtask

  task automatic set_req(input int id, input logic v);
    if (cur) if3.req[id] = v; else if1.req[id] = v;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_gnt"},   m_gnt,   0);
    chk({nm, "_en"},    m_en,    0);
    chk({nm, "_sel"},   m_sel,   0);
    chk({nm, "_alu_a"}, m_a,     0);
    chk({nm, "_alu_b"}, m_b,     0);
    chk({nm, "_rv"},    m_rv,    0);
    chk({nm, "_rid"},   m_rid,   0);
    chk({nm, "_rdata"}, m_rdata, 0);
  endtask

  // Waits (bounded) for the next resp_valid; reports first grant seen.
  task automatic wait_resp(input string nm, output bit got, output logic [3:0] g_seen, output int cyc);
    got = 0; g_seen = 0; cyc = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (m_gnt != 0 && g_seen == 0) g_seen = m_gnt;
      if (m_rv) got = 1;
    end
    chk({nm, "_resp_seen"}, got, 1);
  endtask

  // One single-requester operation with full checking.
  task automatic txn(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp, input int exp_en, input bit chg_b, input string nm);
    logic [3:0] g_seen;
    int en;
    bit got;
    g_seen = 0; en = 0; got = 0;
    set_slice(id, op, a, b);
    set_req(id, 1'b1);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (m_gnt != 0 && g_seen == 0) g_seen = m_gnt;
      if (m_en) begin
        en++;
        chk({nm, "_sel"},   m_sel, op);
        chk({nm, "_alu_a"}, m_a,   a);
        chk({nm, "_alu_b"}, m_b,   b);
        if (chg_b && en == 1) set_slice(id, op, a, 8'h00);
      end
      if (m_rv) got = 1;
    end
    chk({nm, "_resp_seen"}, got, 1);
    if (got) begin
      chk({nm, "_gnt"},    g_seen, 4'b0001 << id);
      chk({nm, "_en_cyc"}, en, exp_en);
      chk({nm, "_rid"},    m_rid, id);
      chk({nm, "_rdata"},  m_rdata, exp);
    end
    set_req(id, 1'b0);
    @(negedge clk);
    chk({nm, "_rv_pulse"}, m_rv, 0);
  endtask

  typedef struct {
    int         id;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic [3:0] g;
    int cyc;
    int en;
    logic [7:0] exp4 [4];

    vecs[0] = '{0, 2'b00, 8'hF0, 8'h3C, 8'h30};
    vecs[1] = '{1, 2'b01, 8'hF0, 8'h3C, 8'hFC};
    vecs[2] = '{2, 2'b10, 8'hF0, 8'h3C, 8'hCF};
    vecs[3] = '{1, 2'b00, 8'hFF, 8'h00, 8'h00};
    vecs[4] = '{2, 2'b11, 8'h55, 8'hAA, 8'hFF};
    vecs[5] = '{3, 2'b10, 8'hFF, 8'hFF, 8'h00};
    vecs[6] = '{0, 2'b01, 8'h00, 8'h00, 8'h00};
    vecs[7] = '{3, 2'b11, 8'hF0, 8'h3C, 8'hCC};

    if1.req = 0; if1.op_bus = 0; if1.a_bus = 0; if1.b_bus = 0;
    if3.req = 0; if3.op_bus = 0; if3.a_bus = 0; if3.b_bus = 0;

    // ---------------- EXEC_CYCLES = 1 instance ----------------
    cur = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst1");
    rst_n1 = 1'b1;
    rst_n3 = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      txn(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1, 1'b0, $sformatf("vec%0d", i));

    // Idle hold: nothing moves, last result stays.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_en",    m_en,    0);
      chk("idle_gnt",   m_gnt,   0);
      chk("idle_rv",    m_rv,    0);
      chk("idle_rdata", m_rdata, 8'hCC);
    end

    // All four requesting; ptr is 0 after serving requester 3.
    exp4[0] = 8'h0A; exp4[1] = 8'hAF; exp4[2] = 8'hF5; exp4[3] = 8'hA5;
    for (int i = 0; i < 4; i++) set_slice(i, 2'(i), 8'hAA, 8'h0F);
    if1.req = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      wait_resp($sformatf("all4_%0d", j), got, g, cyc);
      chk($sformatf("all4_gnt%0d", j),   g, 4'b0001 << j);
      chk($sformatf("all4_rid%0d", j),   m_rid, j);
      chk($sformatf("all4_data%0d", j),  m_rdata, exp4[j]);
      chk($sformatf("all4_spacing%0d", j), cyc, 3);
      if1.req[j] = 1'b0;
    end
    @(negedge clk);

    // Rotation: serve 2 (ptr -> 3), then 0101 wins 0 first, then 2.
    txn(2, 2'b00, 8'hFF, 8'h81, 8'h81, 1, 1'b0, "rot_pre");
    set_slice(0, 2'b11, 8'h0F, 8'hFF);
    set_slice(2, 2'b01, 8'h01, 8'h02);
    if1.req = 4'b0101;
    wait_resp("rot_a", got, g, cyc);
    chk("rot_a_gnt",  g, 4'b0001);
    chk("rot_a_rid",  m_rid, 0);
    chk("rot_a_data", m_rdata, 8'hF0);
    if1.req[0] = 1'b0;
    wait_resp("rot_b", got, g, cyc);
    chk("rot_b_gnt",  g, 4'b0100);
    chk("rot_b_rid",  m_rid, 2);
    chk("rot_b_data", m_rdata, 8'h03);
    if1.req = 0;
    @(negedge clk);

    // ---------------- EXEC_CYCLES = 3 instance ----------------
    cur = 1;
    // b3 changes to 0 during ISSUE; latched operand must win.
    txn(3, 2'b11, 8'hFF, 8'h0F, 8'hF0, 3, 1'b1, "multi");
    txn(1, 2'b00, 8'h0F, 8'hFF, 8'h0F, 3, 1'b0, "multi_id1");

    // ptr = 2: 1010 grants 3 first; reset during its 2nd ISSUE cycle.
    set_slice(1, 2'b01, 8'h11, 8'h22);
    set_slice(3, 2'b00, 8'hFF, 8'hFF);
    if3.req = 4'b1010;
    en = 0; g = 0;
    for (int k = 0; k < 40 && en < 2; k++) begin
      @(negedge clk);
      if (m_gnt != 0 && g == 0) g = m_gnt;
      if (m_en) en++;
    end
    chk("rstmid_reached", en, 2);
    chk("rstmid_gnt_pre", g, 4'b1000);
    rst_n3 = 1'b0;
    #1;
    chk_reset_outputs("rstmid");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstmid_hold_rv", m_rv, 0);
    end
    rst_n3 = 1'b1;
    wait_resp("rstmid_after", got, g, cyc);
    chk("rstmid_after_gnt",  g, 4'b0010);
    chk("rstmid_after_rid",  m_rid, 1);
    chk("rstmid_after_data", m_rdata, 8'h33);
    chk("rstmid_after_cyc",  cyc, 5);
    if3.req = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_logica.md
# arbitro_logica

Round-robin scheduler that shares one 4-operation logic unit among four requesters. The unit is the decoder plus the AND/OR/NAND/XOR datapath. The block picks one pending request, latches its opcode and operands, and drives the decoder's enable and selector for a programmable number of execute cycles. It then captures the unit's result and returns it to the winner, tagged with that requester's index. It sits between the requester ports and the logic unit; the logic unit itself is outside this block.

## Interface
- `WIDTH`, default 8: operand and result width in bits.
- `EXEC_CYCLES`, default 1: number of cycles `dec_enable` stays high per operation. Legal range is 1..15.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset. Asynchronous assert, active-low; deassertion is synchronous to `clk` externally.
- `req`  in  4: request level, one bit per requester.
- `op_bus`  in  8: opcodes. Requester i uses `op_bus[2i+1:2i]`; 00 AND, 01 OR, 10 NAND, 11 XOR.
- `a_bus`  in  4*WIDTH: operand A. Requester i uses slice i.
- `b_bus`  in  4*WIDTH: operand B. Requester i uses slice i.
- `alu_res`  in  WIDTH: combinational result from the logic unit.
- `gnt`  out  4: one-hot grant, held for the whole operation.
- `dec_enable`  out  1: decoder enable.
- `dec_selector`  out  2: decoder selector, carrying the winner's latched opcode.
- `alu_a`  out  WIDTH: latched operand A driven to the logic unit.
- `alu_b`  out  WIDTH: latched operand B driven to the logic unit.
- `resp_valid`  out  1: one-cycle pulse when the result is available.
- `resp_id`  out  2: index of the requester the result belongs to.
- `resp_data`  out  WIDTH: captured result.

## Operation
- The FSM has three states: IDLE, ISSUE, DONE. All outputs are registered.
- IDLE
  - If `req` is nonzero, the arbiter picks the first set bit searching from `ptr` upward, wrapping 3 to 0.
  - On the same edge it latches the winner's opcode and operands, sets `gnt`, loads `cnt = EXEC_CYCLES-1`, and goes to ISSUE.
  - If `req` is zero, it stays in IDLE.
- ISSUE
  - `dec_enable=1`, `dec_selector` = latched opcode, `alu_a`/`alu_b` = latched operands.
  - `cnt` decrements each cycle.
  - When `cnt==0`, the block captures `alu_res` into `resp_data`, sets `resp_id` to the winner index, and goes to DONE.
- DONE
  - `resp_valid=1` for exactly one cycle, and `dec_enable=0`.
  - `ptr` becomes winner+1 mod 4. `gnt` clears and the FSM returns to IDLE.
- Values are latched at grant. Changes on `op_bus`, `a_bus`, `b_bus` or `req` during ISSUE/DONE have no effect on the running operation.
- A requester holds `req` until it sees `resp_valid` with its own `resp_id`. If `req` is still high in IDLE afterwards, it counts as a new request and competes normally under the rotated priority.
- Outside ISSUE, `dec_selector` is 00 and `alu_a`/`alu_b` keep their last latched value.
- `resp_data` and `resp_id` hold their values until the next capture.

## Timing
- Reset values: FSM=IDLE, `ptr=0`, `gnt=0000`, `dec_enable=0`, `dec_selector=00`, `alu_a=alu_b=0`, `resp_valid=0`, `resp_id=00`, `resp_data=0`.
- Reset is asynchronous. Asserting `rst_n` mid-ISSUE or mid-DONE forces all of the above immediately. The aborted operation produces no `resp_valid`.
- Latency from `req` sampled high in IDLE (edge T):
  - ISSUE occupies edges T+1..T+EXEC_CYCLES.
  - `resp_valid` is high during the cycle after edge T+EXEC_CYCLES+1.
- Throughput: one operation per EXEC_CYCLES+2 cycles when requests are continuous.
- Simultaneous requests: exactly one grant per arbitration. A requester with `req` held waits at most 3 other operations.
- `alu_res` is sampled only on the final ISSUE edge. The logic unit must settle within one cycle of `dec_enable`/operands changing.

## Test plan
- **Reset then single request.** `WIDTH=8`, `EXEC_CYCLES=1`. After reset, `req=0001`, op0=00, a0=0xF0, b0=0x3C. Required: `gnt=0001`; one cycle of `dec_enable=1` with `dec_selector=00`; then `resp_valid` pulse with `resp_id=0`, `resp_data=0x30`.
- **All four requesting.** `req=1111`, op i = i, all a=0xAA, all b=0x0F. Required: grants in order 0,1,2,3 and results 0x0A, 0xAF, 0xF5, 0xA5. Each `resp_valid` is 3 cycles apart.
- **Round-robin rotation.** Serve requester 2, then raise `req=0101`. Required: requester 0 is granted next (`ptr=3`, wrapping to 0), then requester 2.
- **Multi-cycle execute.** `EXEC_CYCLES=3`, req3, op=11, a=0xFF, b=0x0F. Required: `dec_enable` high exactly 3 cycles, then `resp_data=0xF0`. Changing b3 to 0x00 during ISSUE leaves the result unchanged.
- **Reset mid-operation.** Pull `rst_n` low in the 2nd ISSUE cycle. Required: all outputs go to their reset values at once, no `resp_valid` appears, and after release a held `req=0010` is granted from `ptr=0` search.
- **Idle hold.** `req=0000` for 20 cycles after an operation. Required: `dec_enable`, `gnt` and `resp_valid` stay 0, and `resp_data` holds its last value.
